full_adder_reg: RTL and testbench

- Registered 3-input combinational function unit producing two outputs from inputs A, B, C.
- F1 = sum (odd parity of A, B, C); F2 = carry (majority of A, B, C), i.e. a one-bit full adder.
- Output stage is registered.
- Also tracks which of the 8 input combinations (minterms) have been applied, for self-coverage during bring-up.

---
 rtl/full_adder_reg.sv | 53 +++++
 tb/tb_full_adder_reg.sv | 111 +++++++++++
 2 files changed

// File: rtl/full_adder_reg.sv
// rtl/full_adder_reg.sv - registered one-bit full adder with input minterm coverage tracking
module full_adder_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  output logic       F1,
  output logic       F2,
  output logic       out_valid,
  output logic [7:0] minterm_seen,
  output logic       all_seen
);

  logic [2:0] idx;
  logic       sum_next;
  logic       carry_next;
  logic [7:0] hit;
  logic [7:0] seen_next;

  always_comb begin
    idx        = {A, B, C};
    sum_next   = A ^ B ^ C;
    carry_next = (A & B) | (B & C) | (A & C);
    hit        = 8'h01 << idx;
    seen_next  = minterm_seen;
    if (in_valid) begin
      seen_next = minterm_seen | hit;
    end
  end

  // all_seen is computed from the post-update coverage so it rises on the
  // same edge that records the last missing minterm.
  always_ff @(posedge clk) begin
    if (rst) begin
      F1           <= 1'b0;
      F2           <= 1'b0;
      out_valid    <= 1'b0;
      minterm_seen <= 8'h00;
      all_seen     <= 1'b0;
    end else begin
      out_valid    <= in_valid;
      minterm_seen <= seen_next;
      all_seen     <= &seen_next;
      if (in_valid) begin
        F1 <= sum_next;
        F2 <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_reg.sv
// tb/tb_full_adder_reg.sv - directed and random self-checking bench for full_adder_reg
module tb_full_adder_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       A, B, C;
  logic       F1, F2, out_valid, all_seen;
  logic [7:0] minterm_seen;

  int total = 0;
  int bad   = 0;

  // Hand-computed {F2,F1} for minterms 0..7.
  logic [1:0] sum_tab [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  full_adder_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .C(C),
    .F1(F1), .F2(F2), .out_valid(out_valid),
    .minterm_seen(minterm_seen), .all_seen(all_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [2:0] abc);
    rst      = r;
    in_valid = v;
    {A, B, C} = abc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] fs, input logic ov,
                           input logic [7:0] ms, input logic as);
    check({tag, "_sum"}, {6'd0, F2, F1}, {6'd0, fs});
    check({tag, "_ov"}, {7'd0, out_valid}, {7'd0, ov});
    check({tag, "_ms"}, minterm_seen, ms);
    check({tag, "_all"}, {7'd0, all_seen}, {7'd0, as});
  endtask

  initial begin
    logic [7:0] exp_m;
    logic [1:0] last_sum;
    logic [2:0] v3;
    logic       vv;

    rst = 1'b1; in_valid = 1'b1; {A, B, C} = 3'b111;

    // Reset wins over a valid 111 input.
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 3'b111);
      check_all("reset", 2'd0, 1'b0, 8'h00, 1'b0);
    end

    // Exhaustive sweep, back to back.
    exp_m = 8'h00;
    for (int k = 0; k < 8; k++) begin
      cyc(1'b0, 1'b1, 3'(k));
      exp_m = exp_m | (8'h01 << k);
      check_all("sweep", sum_tab[k], 1'b1, exp_m, (k == 7));
    end
    check("sweep_final_ms", minterm_seen, 8'hFF);

    // Hold: outputs keep the 101 result while idle.
    cyc(1'b0, 1'b1, 3'b101);
    check_all("hold_acc", 2'b10, 1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 3'b000);
      check_all("hold_idle", 2'b10, 1'b0, 8'hFF, 1'b1);
    end

    // Mid-stream reset drops the 111 input entirely.
    cyc(1'b1, 1'b1, 3'b111);
    check_all("midrst", 2'd0, 1'b0, 8'h00, 1'b0);

    // Stickiness: repeated 010 then 110.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 3'b010);
      check_all("sticky010", 2'b01, 1'b1, 8'h04, 1'b0);
    end
    cyc(1'b0, 1'b1, 3'b110);
    check_all("sticky110", 2'b10, 1'b1, 8'h44, 1'b0);

    // Random traffic from a clean reset.
    cyc(1'b1, 1'b0, 3'b000);
    exp_m    = 8'h00;
    last_sum = 2'd0;
    for (int i = 0; i < 200; i++) begin
      vv = 1'($urandom_range(0, 1));
      v3 = 3'($urandom_range(0, 7));
      cyc(1'b0, vv, v3);
      if (vv) begin
        last_sum = 2'(v3[2]) + 2'(v3[1]) + 2'(v3[0]);
        exp_m    = exp_m | (8'h01 << v3);
      end
      check_all("rand", last_sum, vv, exp_m, (exp_m == 8'hFF));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
